frac_clock_divider_bank: RTL and testbench
==========================================

# frac_clock_divider_bank

Parametrised bank of N independent fractional clock-enable generators for the openPIO state machines. Each channel converts a 16.8-style divider word into a single-cycle enable pulse train with average period int + frac/2^FRAC_W. New divider values are written through a shared configuration port, held in a per-channel shadow register, and applied glitch-free at a period boundary. Per-channel enable and restart inputs allow phase-aligned starts across channels.

## Interface
- N_CH, 4: number of divider channels (1..16).
- INT_W, 16: integer divider field width.
- FRAC_W, 8: fractional divider field width.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset is synchronous, active-high.
- cfg_valid  in  1  write strobe for the configuration port.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel; values >= N_CH are ignored.
- cfg_div  in  INT_W+FRAC_W  divider word: [INT_W+FRAC_W-1:FRAC_W] = int, [FRAC_W-1:0] = frac.
- ch_en  in  N_CH  per-channel run enable (level).
- ch_restart  in  N_CH  per-channel restart (single-cycle pulse).
- out_clkEnable  out  N_CH  per-channel enable pulse, combinational from registered state.
- cfg_pending  out  N_CH  shadow holds a value not yet applied.

## Operation
- Per-channel state: active divider, shadow divider, pending bit, counter cnt (INT_W+1 bits), accumulator acc (FRAC_W bits), period length len (INT_W+1 bits).
- int_eff = (int == 0) ? 2^INT_W : int. len ranges 1..2^INT_W+1.
- out_clkEnable[i] = ch_en[i] & (cnt == len-1) & !reset. On a pulse, cnt <= 0; otherwise cnt <= cnt+1 while enabled.
- On a pulse using config C (see priority below): acc <= (acc + C.frac) mod 2^FRAC_W; len <= C.int_eff + carry, where carry = overflow of acc + C.frac.
- Config C at a pulse: cfg write to this channel in the same cycle (bypass, pending stays 0) > pending shadow (pending clears) > active. C becomes active.
- cfg write in a non-pulse cycle while enabled: shadow <= cfg_div, pending <= 1; a later write before the boundary overwrites the shadow.
- ch_en low: cnt, acc <= 0; len <= int_eff of (write > shadow > active); that value becomes active; pending clears; no pulse.
- ch_restart high (or ch_en rising): same clearing as ch_en low, taking effect the next cycle; restart has priority over a coincident pulse (pulse still shown that cycle, but counters clear).
- Divider 1.0 (int=1, frac=0): pulse every enabled cycle. frac != 0 with int=1: pulse every cycle except a gap when carry lengthens the period to 2.

## Timing
- reset: active = shadow = {int=1, frac=0}, cnt = acc = 0, len = 1, pending = 0; out_clkEnable = 0 while reset is high.
- Restart in cycle T: cnt = 0 at T+1; first pulse at T+int_eff; the first period never includes a fractional carry.
- Config write latency: one cycle to cfg_pending; applied at the next pulse or within one cycle when disabled.
- No backpressure on the config port; every valid write is accepted.

## Structure
- Package frac_clkdiv_pkg: field-width localparams, function int_eff(), divider-word field slice helpers.
- Sub-module frac_clkdiv_channel: one channel's state and datapath, instantiated N_CH times by generate; the top level only decodes cfg_ch into per-channel write strobes.

## Test plan
- Reset, ch_en[0]=1, default divider -> out_clkEnable[0] high every cycle from the first cycle after reset; cfg_pending = 0.
- Write int=2, frac=128 to ch1 while disabled, then restart at T -> pulses at T+2, T+4, T+7, T+9, T+12 (intervals 2,3,2,3).
- ch2 running with int=4; write int=3 mid-period -> cfg_pending[2] = 1 until the next pulse, then period 3; no shortened or doubled pulse.
- Config write coincident with a pulse on ch0 -> new value used for the next period; cfg_pending[0] stays 0.
- int=0, INT_W=4 -> period 16; cfg_ch = N_CH -> no channel changes.
- Restart ch0 and ch3 in the same cycle, both int=5 -> pulses coincide for every subsequent period; reset asserted mid-run -> all outputs 0 next cycle and defaults restored.

Source files
------------

// File: rtl/frac_clkdiv_pkg.sv
// rtl/frac_clkdiv_pkg.sv - shared widths and divider-word helpers for the fractional clock divider bank
package frac_clkdiv_pkg;
  localparam int MAX_INT_W  = 16;
  localparam int MAX_FRAC_W = 16;
  localparam int WORD_W     = 32;

  function automatic logic [MAX_INT_W-1:0] div_int(input logic [WORD_W-1:0] word, input int fracW);
    return MAX_INT_W'(word >> fracW);
  endfunction

  function automatic logic [MAX_FRAC_W-1:0] div_frac(input logic [WORD_W-1:0] word, input int fracW);
    logic [WORD_W-1:0] mask;
    mask = (WORD_W'(1) << fracW) - WORD_W'(1);
    return MAX_FRAC_W'(word & mask);
  endfunction

  // An integer field of zero means the longest period, 2^intW.
  function automatic logic [MAX_INT_W:0] int_eff(input logic [MAX_INT_W-1:0] intField, input int intW);
    return (intField == '0) ? ((MAX_INT_W+1)'(1) << intW) : {1'b0, intField};
  endfunction
endpackage

// File: rtl/frac_clkdiv_channel.sv
// rtl/frac_clkdiv_channel.sv - one fractional clock-enable channel with shadowed divider
module frac_clkdiv_channel
  import frac_clkdiv_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    restart,
  input  logic                    wrValid,
  input  logic [INT_W+FRAC_W-1:0] wrDiv,
  output logic                    clkEnable,
  output logic                    pending
);
  localparam int DIV_W = INT_W + FRAC_W;
  localparam int LEN_W = INT_W + 1;
  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(1) << FRAC_W;

  logic [DIV_W-1:0]  activeDiv;
  logic [DIV_W-1:0]  shadowDiv;
  logic [DIV_W-1:0]  nextDiv;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  nextLen;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] nextFrac;
  logic [FRAC_W:0]   accSum;
  logic              enPrev;
  logic              clearNow;

  // A same-cycle write bypasses the shadow; otherwise a pending shadow wins over the active value.
  assign nextDiv   = wrValid ? wrDiv : (pending ? shadowDiv : activeDiv);
  assign nextFrac  = FRAC_W'(div_frac(WORD_W'(nextDiv), FRAC_W));
  assign nextLen   = LEN_W'(int_eff(div_int(WORD_W'(nextDiv), FRAC_W), INT_W));
  assign accSum    = {1'b0, acc} + {1'b0, nextFrac};
  assign clkEnable = en & (cnt == len - LEN_W'(1)) & ~reset;
  assign clearNow  = ~en | restart | ~enPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      activeDiv <= DEFAULT_DIV;
      shadowDiv <= DEFAULT_DIV;
      pending   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      len       <= LEN_W'(1);
      enPrev    <= 1'b0;
    end else begin
      enPrev <= en;
      if (clearNow) begin
        // Restart beats a coincident pulse: the first period after it never carries.
        cnt       <= '0;
        acc       <= '0;
        len       <= nextLen;
        activeDiv <= nextDiv;
        pending   <= 1'b0;
      end else if (clkEnable) begin
        cnt       <= '0;
        acc       <= accSum[FRAC_W-1:0];
        len       <= nextLen + LEN_W'(accSum[FRAC_W]);
        activeDiv <= nextDiv;
        pending   <= 1'b0;
      end else begin
        cnt <= cnt + LEN_W'(1);
        if (wrValid) begin
          shadowDiv <= wrDiv;
          pending   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/frac_clock_divider_bank.sv
// rtl/frac_clock_divider_bank.sv - bank of independent fractional clock-enable generators
module frac_clock_divider_bank
  import frac_clkdiv_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [INT_W+FRAC_W-1:0] cfg_div,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH-1:0]         ch_restart,
  output logic [N_CH-1:0]         out_clkEnable,
  output logic [N_CH-1:0]         cfg_pending
);
  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    frac_clkdiv_channel #(
      .INT_W (INT_W),
      .FRAC_W(FRAC_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (ch_en[i]),
      .restart  (ch_restart[i]),
      .wrValid  (cfg_valid && (cfg_ch == CH_W'(i))),
      .wrDiv    (cfg_div),
      .clkEnable(out_clkEnable[i]),
      .pending  (cfg_pending[i])
    );
  end
endmodule

// File: tb/tb_frac_clock_divider_bank.sv
// tb/tb_frac_clock_divider_bank.sv - scoreboard bench for frac_clock_divider_bank
module tb_frac_clock_divider_bank;
  localparam int N  = 5;
  localparam int IW = 4;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [2:0]    cfg_ch = '0;
  logic [IW+FW-1:0] cfg_div = '0;
  logic [N-1:0]  ch_en = '0;
  logic [N-1:0]  ch_restart = '0;
  logic [N-1:0]  out_clkEnable;
  logic [N-1:0]  cfg_pending;

  frac_clock_divider_bank #(.N_CH(N), .INT_W(IW), .FRAC_W(FW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .ch_en(ch_en), .ch_restart(ch_restart), .out_clkEnable(out_clkEnable), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [N-1:0] en; logic [N-1:0] pend; } exp_t;
  exp_t expQ[$];
  int   pulseCh[$];
  int   pulseAt[$];
  int   wantQ[$];
  int   nCmp = 0;
  int   nBad = 0;
  bit   done = 0;

  // Reference model: each channel remembers the absolute cycle of its next pulse and its fractional residue.
  int actInt[N], actFrac[N], shInt[N], shFrac[N], nextP[N], resid[N];
  bit pend[N], prevEn[N];
  int modelT = 0;

  function automatic int ieff(input int v);
    return (v == 0) ? (1 << IW) : v;
  endfunction

  task automatic model_reset_state(input int i);
    actInt[i] = 1; actFrac[i] = 0; shInt[i] = 1; shFrac[i] = 0;
    pend[i] = 0; prevEn[i] = 0; resid[i] = 0; nextP[i] = modelT + 1;
  endtask

  task automatic model_step();
    exp_t e;
    e.t = modelT;
    for (int i = 0; i < N; i++) begin
      bit wr;
      int cInt, cFrac, s;
      wr = cfg_valid && (int'(cfg_ch) == i);
      e.en[i]   = !reset && ch_en[i] && (modelT == nextP[i]);
      e.pend[i] = pend[i];
      if (reset) begin
        model_reset_state(i);
      end else begin
        if (wr) begin cInt = int'(cfg_div[IW+FW-1:FW]); cFrac = int'(cfg_div[FW-1:0]); end
        else if (pend[i]) begin cInt = shInt[i]; cFrac = shFrac[i]; end
        else begin cInt = actInt[i]; cFrac = actFrac[i]; end
        if (!ch_en[i] || ch_restart[i] || !prevEn[i]) begin
          actInt[i] = cInt; actFrac[i] = cFrac; pend[i] = 0; resid[i] = 0;
          nextP[i] = modelT + ieff(cInt);
        end else if (e.en[i]) begin
          actInt[i] = cInt; actFrac[i] = cFrac; pend[i] = 0;
          s = resid[i] + cFrac;
          resid[i] = s % (1 << FW);
          nextP[i] = modelT + ieff(cInt) + ((s >= (1 << FW)) ? 1 : 0);
        end else if (wr) begin
          shInt[i] = cInt; shFrac[i] = cFrac; pend[i] = 1;
        end
        prevEn[i] = ch_en[i];
      end
    end
    expQ.push_back(e);
    modelT++;
  endtask

  task automatic drive(input logic [N-1:0] en, input logic [N-1:0] rs, input logic v,
                       input logic [2:0] ch, input logic [IW+FW-1:0] d, input logic r);
    ch_en = en; ch_restart = rs; cfg_valid = v; cfg_ch = ch; cfg_div = d; reset = r;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic [N-1:0] en);
    for (int k = 0; k < n; k++) drive(en, '0, 1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic check_window(input string name, input int ch, input int lo, input int hi);
    int got[$];
    for (int k = 0; k < pulseAt.size(); k++)
      if (pulseCh[k] == ch && pulseAt[k] >= lo && pulseAt[k] <= hi) got.push_back(pulseAt[k]);
    nCmp++;
    if (got.size() != wantQ.size()) begin
      nBad++;
      $display("FAIL %s pulse count: got %0d required %0d", name, got.size(), wantQ.size());
    end else begin
      for (int k = 0; k < got.size(); k++) begin
        nCmp++;
        if (got[k] != wantQ[k]) begin
          nBad++;
          $display("FAIL %s pulse %0d: got cycle %0d required cycle %0d", name, k, got[k], wantQ[k]);
        end
      end
    end
    wantQ.delete();
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nCmp++;
        if (out_clkEnable !== e.en) begin
          nBad++;
          $display("FAIL clkEnable cycle %0d: got %b required %b", e.t, out_clkEnable, e.en);
        end
        nCmp++;
        if (cfg_pending !== e.pend) begin
          nBad++;
          $display("FAIL cfg_pending cycle %0d: got %b required %b", e.t, cfg_pending, e.pend);
        end
        for (int i = 0; i < N; i++)
          if (out_clkEnable[i] === 1'b1) begin pulseCh.push_back(i); pulseAt.push_back(e.t); end
      end
    end
  end

  initial begin : stimulus
    int t0;
    logic [N-1:0] enS;
    for (int i = 0; i < N; i++) model_reset_state(i);
    @(posedge clk); #1;

    // Default divider: pulse every cycle straight out of reset.
    for (int k = 0; k < 3; k++) drive(5'b00001, '0, 1'b0, 3'd0, '0, 1'b1);
    t0 = modelT;
    idle(6, 5'b00001);
    for (int k = 0; k < 6; k++) wantQ.push_back(t0 + k);
    check_window("default_div", 0, t0, t0 + 5);

    // 2 + 128/256 on ch1: intervals 2,3,2,3.
    drive(5'b00001, '0, 1'b1, 3'd1, {4'd2, 8'd128}, 1'b0);
    t0 = modelT;
    drive(5'b00011, 5'b00010, 1'b0, 3'd0, '0, 1'b0);
    idle(13, 5'b00011);
    wantQ = '{t0 + 2, t0 + 4, t0 + 7, t0 + 9, t0 + 12};
    check_window("frac_2p5", 1, t0, t0 + 13);

    // ch2 at 4, rewritten to 3 mid-period.
    drive(5'b00011, '0, 1'b1, 3'd2, {4'd4, 8'd0}, 1'b0);
    t0 = modelT;
    drive(5'b00111, '0, 1'b0, 3'd0, '0, 1'b0);
    idle(4, 5'b00111);
    drive(5'b00111, '0, 1'b1, 3'd2, {4'd3, 8'd0}, 1'b0);
    idle(10, 5'b00111);
    wantQ = '{t0 + 4, t0 + 8, t0 + 11, t0 + 14};
    check_window("shadow_apply", 2, t0, t0 + 15);

    // Write coincident with a ch0 pulse is used immediately.
    t0 = modelT;
    drive(5'b00111, '0, 1'b1, 3'd0, {4'd3, 8'd0}, 1'b0);
    idle(7, 5'b00111);
    wantQ = '{t0, t0 + 3, t0 + 6};
    check_window("bypass_write", 0, t0, t0 + 7);

    // int=0 means 16; an out-of-range channel write is dropped.
    drive(5'b00111, '0, 1'b1, 3'd3, {4'd0, 8'd0}, 1'b0);
    t0 = modelT;
    drive(5'b01111, '0, 1'b0, 3'd0, '0, 1'b0);
    drive(5'b01111, '0, 1'b1, 3'd5, 12'hABC, 1'b0);
    idle(32, 5'b01111);
    wantQ = '{t0 + 16, t0 + 32};
    check_window("int_zero", 3, t0, t0 + 33);

    // Phase-aligned restart of ch0 and ch3, then reset mid-run.
    drive(5'b01111, '0, 1'b1, 3'd0, {4'd5, 8'd0}, 1'b0);
    drive(5'b01111, '0, 1'b1, 3'd3, {4'd5, 8'd0}, 1'b0);
    t0 = modelT;
    drive(5'b01111, 5'b01001, 1'b0, 3'd0, '0, 1'b0);
    idle(15, 5'b01111);
    wantQ = '{t0 + 5, t0 + 10, t0 + 15};
    check_window("aligned_ch0", 0, t0 + 1, t0 + 15);
    wantQ = '{t0 + 5, t0 + 10, t0 + 15};
    check_window("aligned_ch3", 3, t0 + 1, t0 + 15);
    drive(5'b01111, '0, 1'b0, 3'd0, '0, 1'b1);
    drive(5'b11111, '0, 1'b0, 3'd0, '0, 1'b1);
    idle(5, 5'b11111);

    // Randomized traffic against the model.
    enS = '1;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] rs;
      logic [IW+FW-1:0] d;
      int iv;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 29) == 0) enS[i] = ~enS[i];
        rs[i] = ($urandom_range(0, 39) == 0);
      end
      iv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
      d = {4'(iv), 8'($urandom_range(0, 255))};
      drive(enS, rs, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), d,
            ($urandom_range(0, 299) == 0));
    end

    drive(enS, '0, 1'b0, 3'd0, '0, 1'b0);
    @(negedge clk);
    done = 1;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
